bin_to_bcd_seq: RTL

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble) with one bit processed per clock. It sits directly downstream of the registered product of the N-bit multiplier stage and consumes its 2N-bit result. It presents the value as packed decimal digits for the seven-segment display decoders, so products are shown in decimal rather than hex. A start/busy/done handshake lets the upstream register fire a conversion whenever a new product is latched.

---
 rtl/bin_to_bcd_seq_pkg.sv | 29 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 83 ++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, default widths and the digit-count bound.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int N_DEF = 16;
    localparam int D_DEF = 5;

    // Decimal digits needed to represent 2**n - 1.
    function automatic int min_digits(input int n);
        longint unsigned v;
        int d;
        v = (64'd1 << n) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v > 64'd0) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
// Purely combinational; the top instantiates one per output digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one binary bit per clock.
// Turns the registered multiplier product into packed decimal digits.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int D = D_DEF
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           start,
    input  logic [N-1:0]   bin,
    output logic           busy,
    output logic           done,
    output logic [4*D-1:0] bcd
);

    localparam int W  = 4 * D + N;
    localparam int CW = $clog2(N + 1);

    if (D < min_digits(N)) begin : g_bad_d
        $error("bin_to_bcd_seq: D too small for N");
    end

    state_t        state;
    logic [W-1:0]  work;
    logic [W-1:0]  adj;
    logic [W-1:0]  shifted;
    logic [CW-1:0] cnt;

    assign adj[N-1:0] = work[N-1:0];

    for (genvar k = 0; k < D; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (work[N+4*k +: 4]),
            .dout (adj[N+4*k +: 4])
        );
    end

    assign shifted = {adj[W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (aclr) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work  <= {{(4*D){1'b0}}, bin};
                        cnt   <= CW'(N);
                        busy  <= 1'b1;
                        state <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CONV: begin
                    work <= shifted;
                    cnt  <= cnt - CW'(1);
                    // Last shift: publish the result so it is valid in DONE.
                    if (cnt == CW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= shifted[W-1:N];
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
